a2_slot_bus_if: RTL and testbench

- Parametrised Apple II slot bus target for the iCE40 card designs.
- Runs in the clk_16m domain and synchronises the asynchronous slot strobes (_devsel, _iosel, _iostrobe).
- Decodes each bus cycle into single-cycle register or ROM requests for back-end logic (e.g. an SSC/ACIA core).
- Drives the data output bus and its output enable, which feed the SB_IO data pins and the 245 transceiver enable.

---
 rtl/a2_slot_bus_if.sv | 267 ++++++++++++++++++++++++++
 tb/tb_a2_slot_bus_if.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/a2_slot_bus_if.sv
`timescale 1ns/1ps
// a2_slot_bus_if
//   Apple II slot bus target. It runs in the clk_16m domain and synchronises the
//   asynchronous slot strobes, rw, address and data. Each bus cycle becomes a
//   single-cycle register or ROM request for back-end logic. The block also drives
//   the read data bus and its output enable, which feed SB_IO and the 245 enable.
//
//   Build option: `define A2_SLOT_EXPROM_EN enables the $C800 expansion ROM
//   (the exp_active flag, the _iostrobe decode and the $CFFF release). When it is
//   left undefined, _iostrobe is ignored and o_exp_active is tied to 0.
//
// Ports
//   i_clk_16m      16 MHz system clock
//   i_reset_n      asynchronous active-low reset (slot _reset)
//   i_addr[11:0]   bus address A11..A0
//   i_data[7:0]    bus data from SB_IO D_IN
//   i_rw           1 = read, 0 = write
//   i_devsel_n     _devsel strobe  ($C0nX registers)
//   i_iosel_n      _iosel strobe   ($CnXX slot ROM)
//   i_iostrobe_n   _iostrobe       ($C800-$CFFF expansion ROM)
//   o_data[7:0]    read data to SB_IO D_OUT
//   o_data_oe      data pin / 245 drive enable
//   o_reg_addr     register index
//   o_reg_wdata    register write data
//   o_reg_wr       one-clock register write pulse
//   o_reg_rd       one-clock register read pulse
//   i_reg_rdata    register data, valid 1 clk after o_reg_rd
//   o_rom_addr     ROM address
//   o_rom_rd       one-clock ROM read pulse
//   i_rom_rdata    ROM data, valid 1 clk after o_rom_rd
//   o_exp_active   card owns the $C800 expansion space
//
// state  | meaning
// IDLE   | waiting for a synced strobe fall
// REQ    | one clock: issue the reg_rd / rom_rd request
// DRIVE  | one clock: back-end data valid, begin driving the bus
// WAIT   | hold the bus (read) or capture data (write) until the strobe rises
// IGNORE | cycle not for us; wait for the strobe to rise
module a2_slot_bus_if #(
  parameter int DEV_REGS    = 16,
  parameter int SYNC_STAGES = 2,
  parameter int EXP_AW      = 11
) (
  input  logic              i_clk_16m,
  input  logic              i_reset_n,
  input  logic [11:0]       i_addr,
  input  logic [7:0]        i_data,
  input  logic              i_rw,
  input  logic              i_devsel_n,
  input  logic              i_iosel_n,
  input  logic              i_iostrobe_n,
  output logic [7:0]        o_data,
  output logic              o_data_oe,
  output logic [3:0]        o_reg_addr,
  output logic [7:0]        o_reg_wdata,
  output logic              o_reg_wr,
  output logic              o_reg_rd,
  input  logic [7:0]        i_reg_rdata,
  output logic [EXP_AW-1:0] o_rom_addr,
  output logic              o_rom_rd,
  input  logic [7:0]        i_rom_rdata,
  output logic              o_exp_active
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DRIVE,
    S_WAIT,
    S_IGNORE
  } state_t;

  localparam logic [1:0] CYC_DEV   = 2'd0;
  localparam logic [1:0] CYC_IOSEL = 2'd1;
  localparam logic [1:0] CYC_STRB  = 2'd2;

  // Register index mask; also covers DEV_REGS = 1 without a zero-width slice.
  localparam logic [3:0] REG_MASK = 4'(DEV_REGS - 1);

  // Synchroniser word: {rw, iostrobe_n, iosel_n, devsel_n, addr[11:0], data[7:0]}.
  // Every field goes through the same flops, so the fields stay aligned.
  localparam int SW = 24;
  localparam logic [SW-1:0] SYNC_RST = {1'b1, 3'b111, 20'd0};

  logic [SYNC_STAGES-1:0][SW-1:0] r_sync;
  logic [SW-1:0]                  w_bus_in;
  logic [SW-1:0]                  w_sync;
  logic                           w_s_rw;
  logic [2:0]                     w_strb_s;
  logic [11:0]                    w_s_addr;
  logic [7:0]                     w_s_data;
  logic [2:0]                     r_strb_prev;
  logic [2:0]                     w_fall;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_start;
  logic [1:0]  w_cyc_nxt;
  logic        w_reg_rd;
  logic        w_reg_wr;
  logic        w_rom_rd;
  logic [1:0]  r_cyc;
  logic [11:0] r_addr;
  logic        r_rw;
  logic [7:0]  r_reg_wdata;
  logic [7:0]  r_data_out;
  logic [7:0]  w_rdata_sel;
  logic        w_own_n;

  assign w_bus_in = {i_rw, i_iostrobe_n, i_iosel_n, i_devsel_n, i_addr, i_data};
  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_s_rw   = w_sync[23];
  assign w_strb_s = w_sync[22:20];
  assign w_s_addr = w_sync[19:8];
  assign w_s_data = w_sync[7:0];
  assign w_fall   = r_strb_prev & ~w_strb_s;

  always_comb begin
    case (r_cyc)
      CYC_DEV:   w_own_n = w_strb_s[0];
      CYC_IOSEL: w_own_n = w_strb_s[1];
      default:   w_own_n = w_strb_s[2];
    endcase
  end

  assign w_rdata_sel = (r_cyc == CYC_DEV) ? i_reg_rdata : i_rom_rdata;

`ifdef A2_SLOT_EXPROM_EN
  logic r_exp_active;
  logic w_exp_set;
  logic w_exp_clr;
`endif

  always_ff @(posedge i_clk_16m or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_cyc_nxt   = r_cyc;
    w_reg_rd    = 1'b0;
    w_reg_wr    = 1'b0;
    w_rom_rd    = 1'b0;
`ifdef A2_SLOT_EXPROM_EN
    w_exp_set   = 1'b0;
    w_exp_clr   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_fall[0]) begin
          w_start     = 1'b1;
          w_cyc_nxt   = CYC_DEV;
          w_state_nxt = S_REQ;
        end else if (w_fall[1]) begin
          w_start     = 1'b1;
          w_cyc_nxt   = CYC_IOSEL;
          w_state_nxt = S_REQ;
        end
`ifdef A2_SLOT_EXPROM_EN
        else if (w_fall[2]) begin
          w_start   = 1'b1;
          w_cyc_nxt = CYC_STRB;
          // $CFFF releases the expansion space for every card, so it is never served.
          if (w_s_addr[10:0] == 11'h7FF) begin
            w_exp_clr   = 1'b1;
            w_state_nxt = S_IGNORE;
          end else if (!r_exp_active) begin
            w_state_nxt = S_IGNORE;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
`endif
      end
      S_REQ: begin
        if (r_rw) begin
          if (r_cyc == CYC_DEV) w_reg_rd = 1'b1;
          else                  w_rom_rd = 1'b1;
        end
`ifdef A2_SLOT_EXPROM_EN
        if (r_cyc == CYC_IOSEL) w_exp_set = 1'b1;
`endif
        // A strobe that is already gone was a glitch; never drive the bus for it.
        if (w_own_n)   w_state_nxt = S_IDLE;
        else if (r_rw) w_state_nxt = S_DRIVE;
        else           w_state_nxt = S_WAIT;
      end
      S_DRIVE: begin
        w_state_nxt = w_own_n ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (w_own_n) begin
          if (!r_rw && (r_cyc == CYC_DEV)) w_reg_wr = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_IGNORE: begin
        if (w_own_n) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_16m or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync      <= {SYNC_STAGES{SYNC_RST}};
      r_strb_prev <= 3'b111;
      r_cyc       <= CYC_DEV;
      r_addr      <= 12'd0;
      r_rw        <= 1'b1;
      r_reg_wdata <= 8'd0;
      r_data_out  <= 8'd0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], w_bus_in};
      r_strb_prev <= w_strb_s;
      if (w_start) begin
        r_cyc  <= w_cyc_nxt;
        r_addr <= w_s_addr;
        r_rw   <= w_s_rw;
      end
      // Capture only while the strobe is low; the rising-edge sample is not trusted.
      if (((r_state == S_REQ) || (r_state == S_WAIT)) && !r_rw && !w_own_n) begin
        r_reg_wdata <= w_s_data;
      end
      if (r_state == S_DRIVE) begin
        r_data_out <= w_rdata_sel;
      end
    end
  end

`ifdef A2_SLOT_EXPROM_EN
  always_ff @(posedge i_clk_16m or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_exp_active <= 1'b0;
    end else if (w_exp_clr) begin
      r_exp_active <= 1'b0;
    end else if (w_exp_set) begin
      r_exp_active <= 1'b1;
    end
  end

  assign o_exp_active = r_exp_active;
  assign o_rom_addr   = (r_cyc == CYC_STRB) ? r_addr[EXP_AW-1:0] : EXP_AW'(r_addr[7:0]);
`else
  assign o_exp_active = 1'b0;
  assign o_rom_addr   = EXP_AW'(r_addr[7:0]);
`endif

  // During DRIVE the back-end data passes straight through; from then on the latched copy is used.
  assign o_data      = (r_state == S_DRIVE) ? w_rdata_sel : r_data_out;
  assign o_data_oe   = (r_state == S_DRIVE) || ((r_state == S_WAIT) && r_rw);
  assign o_reg_addr  = r_addr[3:0] & REG_MASK;
  assign o_reg_wdata = r_reg_wdata;
  assign o_reg_wr    = w_reg_wr;
  assign o_reg_rd    = w_reg_rd;
  assign o_rom_rd    = w_rom_rd;

  // Address bits above the decoded windows and the unused strobe bits are kept here on purpose.
  logic w_unused;
  assign w_unused = &{1'b0, r_addr, w_strb_s, r_strb_prev, w_fall};

endmodule

// File: tb/tb_a2_slot_bus_if.sv
`timescale 1ns/1ps
module tb_a2_slot_bus_if;

  logic        clk_16m;
  logic        reset_n;
  logic [11:0] addr;
  logic [7:0]  data_in;
  logic        rw;
  logic        devsel_n;
  logic        iosel_n;
  logic        iostrobe_n;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [3:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [7:0]  reg_rdata;
  logic [10:0] rom_addr;
  logic        rom_rd;
  logic [7:0]  rom_rdata;
  logic        exp_active;

  int n_checks = 0;
  int n_errors = 0;

  int          n_reg_rd = 0;
  int          n_reg_wr = 0;
  int          n_rom_rd = 0;
  int          n_oe     = 0;
  logic [3:0]  wr_addr  = '0;
  logic [7:0]  wr_data  = '0;
  logic [10:0] rd_rom_a = '0;
  logic [7:0]  oe_data  = '0;

  int s_reg_rd, s_reg_wr, s_rom_rd, s_oe;

  a2_slot_bus_if #(
    .DEV_REGS(16),
    .SYNC_STAGES(2),
    .EXP_AW(11)
  ) dut (
    .i_clk_16m   (clk_16m),
    .i_reset_n   (reset_n),
    .i_addr      (addr),
    .i_data      (data_in),
    .i_rw        (rw),
    .i_devsel_n  (devsel_n),
    .i_iosel_n   (iosel_n),
    .i_iostrobe_n(iostrobe_n),
    .o_data      (data_out),
    .o_data_oe   (data_oe),
    .o_reg_addr  (reg_addr),
    .o_reg_wdata (reg_wdata),
    .o_reg_wr    (reg_wr),
    .o_reg_rd    (reg_rd),
    .i_reg_rdata (reg_rdata),
    .o_rom_addr  (rom_addr),
    .o_rom_rd    (rom_rd),
    .i_rom_rdata (rom_rdata),
    .o_exp_active(exp_active)
  );

  initial clk_16m = 1'b0;
  always #31.25 clk_16m = ~clk_16m;

  always @(negedge clk_16m) begin
    if (reg_rd) n_reg_rd++;
    if (reg_wr) begin
      n_reg_wr++;
      wr_addr = reg_addr;
      wr_data = reg_wdata;
    end
    if (rom_rd) begin
      n_rom_rd++;
      rd_rom_a = rom_addr;
    end
    if (data_oe) begin
      n_oe++;
      oe_data = data_out;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    s_reg_rd = n_reg_rd;
    s_reg_wr = n_reg_wr;
    s_rom_rd = n_rom_rd;
    s_oe     = n_oe;
  endtask

  // strb bit0 = _devsel, bit1 = _iosel, bit2 = _iostrobe
  task automatic bus_cycle(input logic [2:0] strb, input logic rw_v, input logic [11:0] a,
                           input logic [7:0] d, input int hold);
    @(negedge clk_16m);
    addr = a; data_in = d; rw = rw_v;
    @(negedge clk_16m);
    devsel_n = ~strb[0]; iosel_n = ~strb[1]; iostrobe_n = ~strb[2];
    repeat (hold) @(negedge clk_16m);
    devsel_n = 1'b1; iosel_n = 1'b1; iostrobe_n = 1'b1;
    repeat (6) @(negedge clk_16m);
    rw = 1'b1;
  endtask

`ifdef A2_SLOT_EXPROM_EN
  localparam logic EXP_ON = 1'b1;
`else
  localparam logic EXP_ON = 1'b0;
`endif

  initial begin
    reset_n = 1'b0; addr = '0; data_in = '0; rw = 1'b1;
    devsel_n = 1'b1; iosel_n = 1'b1; iostrobe_n = 1'b1;
    reg_rdata = 8'h00; rom_rdata = 8'h3C;
    repeat (3) @(negedge clk_16m);
    chk("rst_oe", data_oe, 0);
    chk("rst_data", data_out, 0);
    chk("rst_pulses", {reg_rd, reg_wr, rom_rd}, 0);
    chk("rst_exp", exp_active, 0);
    chk("rst_addr", {reg_addr, rom_addr, reg_wdata}, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_16m);

    // Read of $C0nX register 3, strobe low 8 clocks.
    snap();
    addr = 12'h0C3; rw = 1'b1; reg_rdata = 8'hA5;
    @(negedge clk_16m);
    devsel_n = 1'b0;
    @(negedge clk_16m);
    chk("rd_oe_s0", data_oe, 0);
    @(negedge clk_16m);
    chk("rd_oe_s1", {data_oe, reg_rd}, 0);
    @(negedge clk_16m);
    chk("rd_req", {reg_rd, data_oe}, 2'b10);
    chk("rd_reg_addr", reg_addr, 3);
    @(negedge clk_16m);
    chk("rd_drive_oe", data_oe, 1);
    chk("rd_drive_data", data_out, 8'hA5);
    chk("rd_drive_rd", reg_rd, 0);
    @(negedge clk_16m);
    reg_rdata = 8'h00;
    @(negedge clk_16m);
    chk("rd_wait_latched", {data_oe, data_out}, {1'b1, 8'hA5});
    repeat (2) @(negedge clk_16m);
    devsel_n = 1'b1;
    @(negedge clk_16m);
    chk("rd_oe_rise0", data_oe, 1);
    @(negedge clk_16m);
    chk("rd_oe_rise1", data_oe, 1);
    @(negedge clk_16m);
    chk("rd_oe_off", data_oe, 0);
    repeat (3) @(negedge clk_16m);
    chk("rd_single_reg_rd", n_reg_rd - s_reg_rd, 1);
    chk("rd_no_wr", n_reg_wr - s_reg_wr, 0);

    // Write to register 9; data changes mid-strobe and the final value must win.
    snap();
    @(negedge clk_16m);
    addr = 12'h0C9; rw = 1'b0; data_in = 8'h11;
    @(negedge clk_16m);
    devsel_n = 1'b0;
    repeat (3) @(negedge clk_16m);
    data_in = 8'h5A;
    repeat (5) @(negedge clk_16m);
    chk("wr_no_early_wr", n_reg_wr - s_reg_wr, 0);
    devsel_n = 1'b1;
    repeat (6) @(negedge clk_16m);
    rw = 1'b1;
    chk("wr_count", n_reg_wr - s_reg_wr, 1);
    chk("wr_addr", wr_addr, 9);
    chk("wr_data", wr_data, 8'h5A);
    chk("wr_no_oe", n_oe - s_oe, 0);
    chk("wr_no_rd", n_reg_rd - s_reg_rd, 0);

    // _iostrobe before any _iosel access.
    snap();
    bus_cycle(3'b100, 1'b1, 12'h812, 8'h00, 8);
    chk("strb_cold_rom", n_rom_rd - s_rom_rd, 0);
    chk("strb_cold_oe", n_oe - s_oe, 0);
    chk("strb_cold_exp", exp_active, 0);

    // _iosel read of $C305.
    snap();
    bus_cycle(3'b010, 1'b1, 12'h305, 8'h00, 8);
    chk("iosel_rom_rd", n_rom_rd - s_rom_rd, 1);
    chk("iosel_rom_addr", rd_rom_a, 11'h005);
    chk("iosel_data", oe_data, 8'h3C);
    chk("iosel_exp", exp_active, EXP_ON);

    // _iostrobe read of $C812.
    snap();
    bus_cycle(3'b100, 1'b1, 12'h812, 8'h00, 8);
    chk("strb_rom_rd", n_rom_rd - s_rom_rd, EXP_ON ? 1 : 0);
    if (EXP_ON) chk("strb_rom_addr", rd_rom_a, 11'h012);
    chk("strb_oe", (n_oe - s_oe) > 0, EXP_ON);
    chk("strb_exp", exp_active, EXP_ON);

    // $CFFF releases the expansion space.
    snap();
    bus_cycle(3'b100, 1'b1, 12'hFFF, 8'h00, 8);
    chk("cfff_exp", exp_active, 0);
    chk("cfff_rom", n_rom_rd - s_rom_rd, 0);
    chk("cfff_oe", n_oe - s_oe, 0);

    snap();
    bus_cycle(3'b100, 1'b1, 12'h800, 8'h00, 8);
    chk("after_cfff_rom", n_rom_rd - s_rom_rd, 0);
    chk("after_cfff_oe", n_oe - s_oe, 0);

    // _devsel and _iosel together: _devsel wins.
    snap();
    reg_rdata = 8'hC7;
    bus_cycle(3'b011, 1'b1, 12'h0C3, 8'h00, 8);
    chk("prio_reg_rd", n_reg_rd - s_reg_rd, 1);
    chk("prio_rom_rd", n_rom_rd - s_rom_rd, 0);
    chk("prio_exp", exp_active, 0);
    chk("prio_data", oe_data, 8'hC7);

    // Reset during WAIT of a write.
    bus_cycle(3'b010, 1'b1, 12'h3A7, 8'h00, 8);
    chk("pre_rst_exp", exp_active, EXP_ON);
    snap();
    @(negedge clk_16m);
    addr = 12'h0C6; rw = 1'b0; data_in = 8'h77;
    @(negedge clk_16m);
    devsel_n = 1'b0;
    repeat (5) @(negedge clk_16m);
    chk("pre_rst_oe", data_oe, 0);
    chk("pre_rst_wdata", reg_wdata, 8'h77);
    #5 reset_n = 1'b0;
    #1;
    chk("mid_rst_oe", data_oe, 0);
    chk("mid_rst_pulses", {reg_rd, reg_wr, rom_rd}, 0);
    chk("mid_rst_exp", exp_active, 0);
    chk("mid_rst_regs", {reg_addr, reg_wdata, data_out}, 0);
    chk("mid_rst_rom_addr", rom_addr, 0);
    @(negedge clk_16m);
    devsel_n = 1'b1;
    repeat (4) @(negedge clk_16m);
    reset_n = 1'b1;
    repeat (6) @(negedge clk_16m);
    rw = 1'b1;
    chk("rst_no_wr", n_reg_wr - s_reg_wr, 0);
    chk("rst_no_oe", n_oe - s_oe, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
